// File: rtl/alu_writeback.sv
// alu_writeback: ALU result writeback stage.
//   Buffers ALU register writes in a small FIFO ahead of the register file,
//   maintains the flag register, and evaluates branch conditions against the
//   flags as they stood before the current edge.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   alu_valid/alu_ready             ALU result handshake
//   alu_value, alu_dest, alu_wb_en  register write request (r0 is never written)
//   alu_flag_en, alu_carry, alu_zero, alu_msb, alu_overflow   flag update
//   rf_we, rf_waddr, rf_wdata, rf_ready   register-file write handshake
//   flags                           flag register {overflow, msb, carry, zero}
//   br_req, br_cond                 branch-condition request
//   br_valid, br_taken              one-cycle branch result
module alu_writeback #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [31:0] alu_value,
  input  logic [4:0]  alu_dest,
  input  logic        alu_wb_en,
  input  logic        alu_flag_en,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_msb,
  input  logic        alu_overflow,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic        rf_ready,
  output logic [3:0]  flags,
  input  logic        br_req,
  input  logic [2:0]  br_cond,
  output logic        br_valid,
  output logic        br_taken
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} buf_state_t;

  logic [CNT_W-1:0]  count_p1;
  logic [PTR_W-1:0]  wr_ptr_p1;
  logic [PTR_W-1:0]  rd_ptr_p1;
  logic [4:0]        dest_mem_p1 [DEPTH];
  logic [DATA_W-1:0] data_mem_p1 [DEPTH];
  logic [3:0]        flags_p1;
  logic              br_vld_p1;
  logic              br_taken_p1;

  buf_state_t buf_state;
  logic       transfer;
  logic       push;
  logic       pop;

  // Flag vector layout: {overflow, msb, carry, zero}
  function automatic logic br_eval(input logic [2:0] cond, input logic [3:0] f);
    logic r;
    case (cond)
      3'd0:    r = 1'b1;
      3'd1:    r = f[0];
      3'd2:    r = ~f[0];
      3'd3:    r = f[1];
      3'd4:    r = ~f[1];
      3'd5:    r = f[2];
      3'd6:    r = ~f[2];
      default: r = f[3];
    endcase
    return r;
  endfunction

  always_comb begin
    buf_state = PARTIAL;
    if (count_p1 == '0)
      buf_state = EMPTY;
    else if (count_p1 == CNT_W'(DEPTH))
      buf_state = FULL;
  end

  // Outputs are gated by reset so nothing stale is visible during the reset cycle
  assign alu_ready = ~reset && (buf_state != FULL);
  assign transfer  = alu_valid && alu_ready;
  assign push      = transfer && alu_wb_en && (alu_dest != 5'd0);

  assign rf_we     = ~reset && (buf_state != EMPTY);
  assign pop       = rf_we && rf_ready;
  assign rf_waddr  = rf_we ? dest_mem_p1[rd_ptr_p1] : 5'd0;
  assign rf_wdata  = rf_we ? data_mem_p1[rd_ptr_p1] : '0;

  assign flags     = reset ? 4'd0 : flags_p1;
  assign br_valid  = ~reset && br_vld_p1;
  assign br_taken  = br_valid && br_taken_p1;

  // ---- stage p0 -> p1: control state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      count_p1    <= '0;
      wr_ptr_p1   <= '0;
      rd_ptr_p1   <= '0;
      flags_p1    <= 4'd0;
      br_vld_p1   <= 1'b0;
      br_taken_p1 <= 1'b0;
    end else begin
      // Power-of-two DEPTH makes natural pointer overflow the modulo wrap
      if (push) wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
      if (pop)  rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_p1 <= count_p1 + CNT_W'(1);
        2'b01:   count_p1 <= count_p1 - CNT_W'(1);
        default: count_p1 <= count_p1;
      endcase
      if (transfer && alu_flag_en)
        flags_p1 <= {alu_overflow, alu_msb, alu_carry, alu_zero};
      // Evaluated on the pre-edge flags: a same-edge update is not seen
      br_vld_p1   <= br_req;
      br_taken_p1 <= br_req && br_eval(br_cond, flags_p1);
    end
  end

  // ---- stage p0 -> p1: buffer storage ----
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem_p1[wr_ptr_p1] <= alu_dest;
      data_mem_p1[wr_ptr_p1] <= alu_value;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [31:0] alu_value;
  logic [4:0]  alu_dest;
  logic        alu_wb_en;
  logic        alu_flag_en;
  logic        alu_carry, alu_zero, alu_msb, alu_overflow;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_ready;
  logic [3:0]  flags;
  logic        br_req;
  logic [2:0]  br_cond;
  logic        br_valid;
  logic        br_taken;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_value(alu_value), .alu_dest(alu_dest), .alu_wb_en(alu_wb_en),
    .alu_flag_en(alu_flag_en), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_msb(alu_msb), .alu_overflow(alu_overflow),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .flags(flags), .br_req(br_req), .br_cond(br_cond),
    .br_valid(br_valid), .br_taken(br_taken)
  );

  // Behavioural reference: a queue of pending writes plus flag/branch state
  typedef struct { logic [4:0] d; logic [31:0] v; } wr_t;
  wr_t        m_q[$];
  logic [3:0] m_flags = 4'd0;
  logic       m_brv = 1'b0;
  logic       m_brt = 1'b0;

  function automatic logic cond_true(input logic [2:0] c, input logic [3:0] f);
    logic z, cy, n, v;
    {v, n, cy, z} = f;
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return cy;
      3'd4: return !cy;
      3'd5: return n;
      3'd6: return !n;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    logic ready, acc, pop_now;
    wr_t e;
    ready   = !reset && (m_q.size() < DEPTH);
    acc     = alu_valid && ready;
    pop_now = !reset && (m_q.size() != 0) && rf_ready;
    if (reset) begin
      m_q.delete();
      m_flags = 4'd0;
      m_brv   = 1'b0;
      m_brt   = 1'b0;
    end else begin
      m_brv = br_req;
      m_brt = br_req && cond_true(br_cond, m_flags);
      if (pop_now) void'(m_q.pop_front());
      if (acc && alu_wb_en && alu_dest != 0) begin
        e.d = alu_dest;
        e.v = alu_value;
        m_q.push_back(e);
      end
      if (acc && alu_flag_en) m_flags = {alu_overflow, alu_msb, alu_carry, alu_zero};
    end
  end

  task automatic idle_inputs();
    alu_valid = 0; alu_value = 0; alu_dest = 0; alu_wb_en = 0; alu_flag_en = 0;
    alu_carry = 0; alu_zero = 0; alu_msb = 0; alu_overflow = 0;
    rf_ready = 0; br_req = 0; br_cond = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1;
    next_cycle();
    next_cycle();
    reset = 0;
  endtask

  task automatic push_req(input logic [4:0] d, input logic [31:0] v);
    alu_valid = 1; alu_dest = d; alu_value = v; alu_wb_en = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({alu_ready, rf_we, rf_waddr, rf_wdata, flags, br_valid, br_taken} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b we=%b waddr=%0d wdata=%h flags=%b bv=%b bt=%b, required all zero",
               alu_ready, rf_we, rf_waddr, rf_wdata, flags, br_valid, br_taken);
    end
    next_cycle();
    reset = 0;
    @(negedge clk);
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, required 1", alu_ready);
    end
    next_cycle();
  endtask

  task automatic test_single_write();
    apply_reset();
    push_req(5'd3, 32'h0000_00FF);
    rf_ready = 1;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL single_no_bypass: rf_we=%b, required 0", rf_we);
    end
    next_cycle();
    alu_valid = 0;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h0000_00FF}) begin
      errors++;
      $display("FAIL single_write: we=%b waddr=%0d wdata=%h, required 1 3 000000ff", rf_we, rf_waddr, rf_wdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: rf_we=%b, required 0", rf_we);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rf_ready = 0;
    push_req(5'd1, 32'h11);
    next_cycle();
    push_req(5'd2, 32'h22);
    next_cycle();
    push_req(5'd3, 32'h33);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({alu_ready, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd1, 32'h11}) begin
        errors++;
        $display("FAIL full_hold[%0d]: ready=%b we=%b waddr=%0d wdata=%h, required 0 1 1 00000011",
                 i, alu_ready, rf_we, rf_waddr, rf_wdata);
      end
      next_cycle();
    end
    rf_ready = 1;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({alu_ready, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 32'h22}) begin
      errors++;
      $display("FAIL drain_second: ready=%b waddr=%0d wdata=%h, required 1 2 00000022", alu_ready, rf_waddr, rf_wdata);
    end
    next_cycle();
    alu_valid = 0;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h33}) begin
      errors++;
      $display("FAIL drain_third: we=%b waddr=%0d wdata=%h, required 1 3 00000033", rf_we, rf_waddr, rf_wdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: rf_we=%b, required 0", rf_we);
    end
  endtask

  task automatic test_r0_flags();
    apply_reset();
    push_req(5'd0, 32'hDEAD_BEEF);
    alu_flag_en = 1; alu_zero = 1;
    rf_ready = 1;
    next_cycle();
    idle_inputs();
    rf_ready = 1;
    @(negedge clk);
    checks++;
    if ({rf_we, flags} !== {1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL r0_flags: rf_we=%b flags=%b, required 0 0001", rf_we, flags);
    end
    alu_valid = 1; alu_flag_en = 1; alu_overflow = 1; alu_msb = 1;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (flags !== 4'b1100) begin
      errors++;
      $display("FAIL flags_order: flags=%b, required 1100", flags);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (flags !== 4'b1100) begin
      errors++;
      $display("FAIL flags_hold: flags=%b, required 1100", flags);
    end
  endtask

  task automatic test_branch_hazard();
    apply_reset();
    alu_valid = 1; alu_flag_en = 1; alu_zero = 1;
    br_req = 1; br_cond = 3'b001;
    next_cycle();
    idle_inputs();
    br_req = 1; br_cond = 3'b001;
    @(negedge clk);
    checks++;
    if ({br_valid, br_taken, flags} !== {1'b1, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL branch_old_flags: bv=%b bt=%b flags=%b, required 1 0 0001", br_valid, br_taken, flags);
    end
    next_cycle();
    br_cond = 3'b010;
    @(negedge clk);
    checks++;
    if ({br_valid, br_taken} !== 2'b11) begin
      errors++;
      $display("FAIL branch_new_flags: bv=%b bt=%b, required 1 1", br_valid, br_taken);
    end
    next_cycle();
    br_req = 0;
    @(negedge clk);
    checks++;
    if ({br_valid, br_taken} !== 2'b10) begin
      errors++;
      $display("FAIL branch_not_zero: bv=%b bt=%b, required 1 0", br_valid, br_taken);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({br_valid, br_taken} !== 2'b00) begin
      errors++;
      $display("FAIL branch_idle: bv=%b bt=%b, required 0 0", br_valid, br_taken);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rf_ready = 0;
    push_req(5'd7, 32'h77);
    alu_flag_en = 1; alu_carry = 1;
    next_cycle();
    push_req(5'd8, 32'h88);
    alu_flag_en = 0;
    br_req = 1;
    next_cycle();
    idle_inputs();
    reset = 1;
    @(negedge clk);
    checks++;
    if ({rf_we, flags, br_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_during: we=%b flags=%b bv=%b, required 0 0000 0", rf_we, flags, br_valid);
    end
    next_cycle();
    reset = 0;
    rf_ready = 1;
    @(negedge clk);
    checks++;
    if ({rf_we, flags, alu_ready, br_valid} !== {1'b0, 4'b0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_after: we=%b flags=%b ready=%b bv=%b, required 0 0000 1 0",
               rf_we, flags, alu_ready, br_valid);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_stale[%0d]: rf_we=%b waddr=%0d, required no write", i, rf_we, rf_waddr);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 49) == 0);
      alu_valid    = ($urandom_range(0, 9) < 7);
      alu_value    = $urandom();
      alu_dest     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      alu_wb_en    = ($urandom_range(0, 9) < 8);
      alu_flag_en  = $urandom_range(0, 1);
      {alu_overflow, alu_msb, alu_carry, alu_zero} = 4'($urandom_range(0, 15));
      rf_ready     = ($urandom_range(0, 9) < 5);
      br_req       = $urandom_range(0, 1);
      br_cond      = 3'($urandom_range(0, 7));
      @(negedge clk);
      checks++;
      if (alu_ready !== (!reset && m_q.size() < DEPTH)) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b, required %b", n, alu_ready, !reset && m_q.size() < DEPTH);
      end
      checks++;
      if (rf_we !== (!reset && m_q.size() != 0)) begin
        errors++;
        $display("FAIL rand_we[%0d]: got %b, required %b", n, rf_we, !reset && m_q.size() != 0);
      end else if (rf_we && {rf_waddr, rf_wdata} !== {m_q[0].d, m_q[0].v}) begin
        errors++;
        $display("FAIL rand_head[%0d]: waddr=%0d wdata=%h, required %0d %h", n, rf_waddr, rf_wdata, m_q[0].d, m_q[0].v);
      end
      checks++;
      if (flags !== (reset ? 4'd0 : m_flags)) begin
        errors++;
        $display("FAIL rand_flags[%0d]: got %b, required %b", n, flags, reset ? 4'd0 : m_flags);
      end
      checks++;
      if ({br_valid, br_taken} !== (reset ? 2'b00 : {m_brv, m_brt})) begin
        errors++;
        $display("FAIL rand_branch[%0d]: got %b%b, required %b%b", n, br_valid, br_taken,
                 !reset && m_brv, !reset && m_brt);
      end
      next_cycle();
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_backpressure();
    test_r0_flags();
    test_branch_hazard();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DEPTH, default 2, is the result buffer depth; legal values are powers of two, 2..8.
REQ-002 Port clk, input, 1 bit, is the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit, is the reset, synchronous and active-high.
REQ-004 Port alu_valid, input, 1 bit, marks a valid ALU result this cycle.
REQ-005 Port alu_ready, output, 1 bit, means the block accepts an ALU result this cycle.
REQ-006 Port alu_value, input, 32 bits, is the ALU result value.
REQ-007 Port alu_dest, input, 5 bits, is the destination register index.
REQ-008 Port alu_wb_en, input, 1 bit, requests a register write of alu_value.
REQ-009 Port alu_flag_en, input, 1 bit, requests a flag register update.
REQ-010 Ports alu_carry, alu_zero, alu_msb and alu_overflow are inputs, 1 bit each, carrying the ALU flags.
REQ-011 Port rf_we, output, 1 bit, is the register-file write request.
REQ-012 Port rf_waddr, output, 5 bits, is the write address.
REQ-013 Port rf_wdata, output, 32 bits, is the write data.
REQ-014 Port rf_ready, input, 1 bit, means the register file accepts the write this cycle.
REQ-015 Port flags, output, 4 bits, is the flag register in the order {overflow, msb, carry, zero}.
REQ-016 Port br_req, input, 1 bit, requests a branch-condition evaluation.
REQ-017 Port br_cond, input, 3 bits, selects the branch condition.
REQ-018 Port br_valid, output, 1 bit, is a one-cycle pulse marking br_taken valid.
REQ-019 Port br_taken, output, 1 bit, is the branch-condition result.

Function
REQ-020 An ALU transfer SHALL occur when alu_valid and alu_ready are both 1 at a rising clock edge.
REQ-021 alu_ready SHALL be 1 exactly when buffer occupancy is below DEPTH and reset is 0; it is a function of registered state and reset only, with no dependence on rf_ready.
REQ-022 A transfer with alu_wb_en=1 and alu_dest≠0 SHALL push {alu_dest, alu_value} into the FIFO result buffer.
REQ-023 A transfer with alu_wb_en=0 or alu_dest=0 SHALL push nothing; register r0 is never written.
REQ-024 The buffer SHALL have three states, EMPTY, PARTIAL and FULL, derived from an occupancy counter (0..DEPTH) and wrap-around read/write pointers.
REQ-025 Pointers SHALL wrap modulo DEPTH.
REQ-026 rf_we SHALL be 1 exactly when the buffer is not EMPTY; rf_waddr and rf_wdata SHALL present the head entry and stay stable until it is popped.
REQ-027 A pop SHALL occur when rf_we and rf_ready are both 1 at a rising clock edge.
REQ-028 Write latency SHALL be 1 cycle: an entry pushed at edge N appears on rf_* in the cycle after edge N; there is no same-cycle bypass.
REQ-029 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-030 A push while FULL SHALL be impossible because alu_ready is 0; alu_valid asserted while FULL is held off and does not overwrite.
REQ-031 rf_we, rf_waddr and rf_wdata SHALL keep their values while rf_ready is 0.
REQ-032 A transfer with alu_flag_en=1 SHALL load flags with {alu_overflow, alu_msb, alu_carry, alu_zero} at that edge, independent of alu_wb_en.
REQ-033 Otherwise flags SHALL hold their value.
REQ-034 A br_req sampled at edge N SHALL drive br_valid=1 for the cycle following edge N.
REQ-035 br_taken SHALL be evaluated against the flag value held before edge N; a same-edge flag update is not visible to that evaluation.
REQ-036 br_cond encoding SHALL be: 000 always, 001 zero, 010 not zero, 011 carry, 100 not carry, 101 msb=1, 110 msb=0, 111 overflow.
REQ-037 br_taken SHALL be 0 whenever br_valid is 0.
REQ-038 Back-to-back br_req SHALL produce one br_valid pulse per request, with no gaps.

Reset
REQ-039 While reset is 1, the block SHALL force alu_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0, flags=0000, br_valid=0 and br_taken=0.
REQ-040 While reset is 1, the block SHALL clear occupancy and both pointers.
REQ-041 Reset asserted mid-operation SHALL discard all buffered entries and any pending branch evaluation.
REQ-042 In the first cycle after reset deasserts, alu_ready SHALL be 1.

Verification
REQ-043 Scenario: push alu_dest=3, alu_value=0x0000_00FF with rf_ready=1 -> rf_we=1, rf_waddr=3, rf_wdata=0x0000_00FF exactly one cycle later, then rf_we=0.
REQ-044 Scenario: with DEPTH=2 and rf_ready=0, three consecutive transfers (dest 1, 2, 3) -> alu_ready=0 after two accepted; raising rf_ready pops 1 then 2, and dest 3 is accepted afterward in order.
REQ-045 Scenario: transfer with alu_wb_en=1, alu_dest=0, alu_flag_en=1, alu_zero=1 -> no rf_we; flags=0001.
REQ-046 Scenario: flags=0000, then br_req with br_cond=001 on the same edge as a flag update setting zero -> br_taken=0; a repeat br_req one cycle later -> br_taken=1.
REQ-047 Scenario: buffer holding 2 entries, reset pulsed for 1 cycle -> rf_we=0, flags=0000, alu_ready=1 in the following cycle, and no stale writes ever appear.
